aes_mix_columns_iter: RTL and testbench

//   Parametrised MixColumns / InvMixColumns engine for the AES datapath. Accepts a
//   128-bit state over a valid/ready handshake, transforms COLS_PER_CYCLE columns
//   per clock, and presents the result over a valid/ready output. It sits between

---
 rtl/aes_pkg.sv | 30 +++
 rtl/aes_mix_column_unit.sv | 41 ++++
 rtl/aes_mix_columns_iter.sv | 132 +++++++++++++
 tb/tb_aes_mix_columns_iter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: GF(2^8) helpers and the MixColumns engine state encoding.
package aes_pkg;

    localparam logic [7:0] AES_GF_POLY = 8'h1b;

    typedef enum logic [1:0] {
        MC_IDLE = 2'b00,
        MC_BUSY = 2'b01,
        MC_DONE = 2'b10
    } mc_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_GF_POLY : 8'h00);
    endfunction

    // Multiply by a 4-bit constant through its binary decomposition (covers 1,2,3,9,b,d,e).
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [3:0] coeff);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (coeff[0] ? x  : 8'h00) ^
               (coeff[1] ? x2 : 8'h00) ^
               (coeff[2] ? x4 : 8'h00) ^
               (coeff[3] ? x8 : 8'h00);
    endfunction

endpackage

// File: rtl/aes_mix_column_unit.sv
// Combinational MixColumns / InvMixColumns on one 32-bit column (row 0 in the MSBs).
module aes_mix_column_unit
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    input  logic        inv,
    output logic [31:0] col_out
);

    logic [7:0] a_s    [4];
    logic [7:0] b_s    [4];
    logic [3:0] coef_s [4];

    // Circulant matrix product: row r uses the coefficient row rotated right by r.
    always_comb begin
        a_s[0] = col_in[31:24];
        a_s[1] = col_in[23:16];
        a_s[2] = col_in[15:8];
        a_s[3] = col_in[7:0];
        if (inv) begin
            coef_s[0] = 4'he;
            coef_s[1] = 4'hb;
            coef_s[2] = 4'hd;
            coef_s[3] = 4'h9;
        end else begin
            coef_s[0] = 4'h2;
            coef_s[1] = 4'h3;
            coef_s[2] = 4'h1;
            coef_s[3] = 4'h1;
        end
        for (int r = 0; r < 4; r++) begin
            b_s[2'(r)] = 8'h00;
            for (int k = 0; k < 4; k++) begin
                b_s[2'(r)] = b_s[2'(r)] ^ gf_mul(a_s[2'(k)], coef_s[2'(k - r)]);
            end
        end
    end

    assign col_out = {b_s[0], b_s[1], b_s[2], b_s[3]};

endmodule

// File: rtl/aes_mix_columns_iter.sv
// Iterative MixColumns engine: loads a 128-bit state, transforms COLS_PER_CYCLE
// columns per clock in place, then holds the result until downstream takes it.
module aes_mix_columns_iter
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    localparam int CYCLES = 4 / COLS_PER_CYCLE;
    localparam int IDX_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("aes_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    mc_state_t        state_r;
    mc_state_t        state_nxt_s;
    logic [IDX_W-1:0] col_idx_r;
    logic [31:0]      cols_r      [4];
    logic [31:0]      cols_nxt_s  [4];
    logic             mode_r;
    logic             out_valid_r;
    logic             accept_s;
    logic             last_col_s;
    logic [1:0]       col_pos_s   [COLS_PER_CYCLE];
    logic [31:0]      col_in_s    [COLS_PER_CYCLE];
    logic [31:0]      col_out_s   [COLS_PER_CYCLE];

    assign in_ready   = (state_r == MC_IDLE) | ((state_r == MC_DONE) & out_ready);
    assign accept_s   = in_valid & in_ready;
    assign last_col_s = (col_idx_r == IDX_W'(CYCLES - 1));
    assign out_valid  = out_valid_r;
    assign out_data   = {cols_r[0], cols_r[1], cols_r[2], cols_r[3]};

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= MC_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state; DONE with out_ready and in_valid re-enters BUSY without an idle gap
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            MC_IDLE: begin
                if (accept_s) state_nxt_s = MC_BUSY;
                else          state_nxt_s = MC_IDLE;
            end
            MC_BUSY: begin
                if (last_col_s) state_nxt_s = MC_DONE;
                else            state_nxt_s = MC_BUSY;
            end
            MC_DONE: begin
                if (out_ready) state_nxt_s = in_valid ? MC_BUSY : MC_IDLE;
                else           state_nxt_s = MC_DONE;
            end
            default: state_nxt_s = MC_IDLE;
        endcase
    end

    // Select the columns handled this clock, lowest column index (MSBs) first
    always_comb begin
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            col_pos_s[g] = 2'(int'(col_idx_r) * COLS_PER_CYCLE + g);
            col_in_s[g]  = cols_r[col_pos_s[g]];
        end
    end

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_unit
        aes_mix_column_unit u_col (
            .col_in  (col_in_s[g]),
            .inv     (mode_r),
            .col_out (col_out_s[g])
        );
    end

    // State next value: load on accept, in-place column writeback while busy
    always_comb begin
        cols_nxt_s = cols_r;
        if (accept_s) begin
            cols_nxt_s[0] = in_data[127:96];
            cols_nxt_s[1] = in_data[95:64];
            cols_nxt_s[2] = in_data[63:32];
            cols_nxt_s[3] = in_data[31:0];
        end else if (state_r == MC_BUSY) begin
            for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                cols_nxt_s[col_pos_s[g]] = col_out_s[g];
            end
        end else begin
            cols_nxt_s = cols_r;
        end
    end

    // Datapath registers and registered out_valid decode
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < 4; c++) begin
                cols_r[c] <= 32'h0000_0000;
            end
            mode_r      <= 1'b0;
            col_idx_r   <= {IDX_W{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            cols_r <= cols_nxt_s;
            if (accept_s) begin
                mode_r    <= in_inv;
                col_idx_r <= {IDX_W{1'b0}};
            end else if (state_r == MC_BUSY) begin
                mode_r    <= mode_r;
                col_idx_r <= last_col_s ? {IDX_W{1'b0}} : col_idx_r + IDX_W'(1);
            end else begin
                mode_r    <= mode_r;
                col_idx_r <= col_idx_r;
            end
            out_valid_r <= (state_nxt_s == MC_DONE);
        end
    end

endmodule

// File: tb/tb_aes_mix_columns_iter.sv
// Scoreboard bench for aes_mix_columns_iter: driver queues expected results on
// accept, a negedge monitor pops and compares on every output transfer.
module tb_aes_mix_columns_iter;

    parameter int COLS_PER_CYCLE = 1;
    localparam int CYCLES = 4 / COLS_PER_CYCLE;

    localparam logic [127:0] V1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] R1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V2 = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
    localparam logic [127:0] R2 = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = 128'h0;
    logic         in_inv = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int transfers = 0;
    bit seen_valid = 1'b0;
    bit rand_en = 1'b0;
    logic [127:0] exp_q[$];
    int acc_q[$];

    aes_mix_columns_iter #(.COLS_PER_CYCLE(COLS_PER_CYCLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_inv    (in_inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: shift-and-add GF(2^8) multiply, independent of the RTL helpers.
    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] m_coef(input logic inv, input int idx);
        case (idx)
            0:       return inv ? 8'h0e : 8'h02;
            1:       return inv ? 8'h0b : 8'h03;
            2:       return inv ? 8'h0d : 8'h01;
            default: return inv ? 8'h09 : 8'h01;
        endcase
    endfunction

    function automatic logic [127:0] model(input logic [127:0] d, input logic inv);
        logic [127:0] res;
        logic [31:0]  col;
        logic [7:0]   a [4];
        logic [7:0]   b;
        res = 128'h0;
        for (int c = 0; c < 4; c++) begin
            col = 32'(d >> (96 - 32 * c));
            for (int k = 0; k < 4; k++) a[k] = 8'(col >> (24 - 8 * k));
            for (int r = 0; r < 4; r++) begin
                b = 8'h00;
                for (int k = 0; k < 4; k++) b = b ^ m_mul(a[k], m_coef(inv, (k - r + 4) % 4));
                res = {res[119:0], b};
            end
        end
        return res;
    endfunction

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: latency on first out_valid, stability under stall, result on transfer
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h with empty scoreboard", out_data);
            end else begin
                if (!seen_valid) begin
                    seen_valid = 1'b1;
                    check("latency", 128'(cyc - acc_q[0]), 128'(CYCLES));
                end
                if (!out_ready) begin
                    check("stall_data", out_data, exp_q[0]);
                    check("stall_in_ready", 128'(in_ready), 128'(0));
                end else begin
                    check("result", out_data, exp_q[0]);
                    check("done_in_ready", 128'(in_ready), 128'(1));
                    void'(exp_q.pop_front());
                    void'(acc_q.pop_front());
                    seen_valid = 1'b0;
                    transfers++;
                end
            end
        end
    end

    // Random output backpressure while enabled
    always @(posedge clk) begin
        #1;
        if (rand_en) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [127:0] d, input logic inv, input logic [127:0] exp, output int acc);
        int  n;
        bit  ok;
        n  = 0;
        ok = 1'b0;
        acc = -1;
        in_valid = 1'b1;
        in_data  = d;
        in_inv   = inv;
        while (n < 200) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
        if (ok) begin
            acc = cyc + 1;
            exp_q.push_back(exp);
            acc_q.push_back(acc);
        end else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results pending, expected 0", exp_q.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, a3, t0, n;
        logic [127:0] d, fwd;
        logic inv;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 128'(out_valid), 128'(0));
        check("reset_out_data", out_data, 128'h0);
        check("reset_in_ready", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Forward and inverse directed vectors
        out_ready = 1'b1;
        send(V1, 1'b0, R1, a1);
        wait_idle();
        send(V2, 1'b1, R2, a1);
        wait_idle();

        // Backpressure with input churn
        out_ready = 1'b0;
        send(V1, 1'b0, R1, a1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", 128'(out_valid), 128'(1));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            in_data = {$urandom, $urandom, $urandom, $urandom};
            in_inv  = ~in_inv;
        end
        t0 = transfers;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_one_transfer", 128'(transfers), 128'(t0 + 1));
        check("bp_valid_cleared", 128'(out_valid), 128'(0));
        @(posedge clk);
        #1;

        // Back-to-back blocks with in_valid and out_ready held high
        out_ready = 1'b1;
        send(V1, 1'b0, R1, a1);
        send(V2, 1'b1, R2, a2);
        send(V1, 1'b0, R1, a3);
        check("b2b_spacing_1", 128'(a2 - a1), 128'(CYCLES + 1));
        check("b2b_spacing_2", 128'(a3 - a2), 128'(CYCLES + 1));
        wait_idle();

        // Reset while busy (col_idx=1 when one column per clock); aborted block must vanish
        send(V2, 1'b1, R2, a1);
        repeat ((CYCLES > 1) ? 1 : 0) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        seen_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_out_valid", 128'(out_valid), 128'(0));
        check("midrst_out_data", out_data, 128'h0);
        check("midrst_in_ready", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        send(V1, 1'b0, R1, a1);
        wait_idle();

        // Randomised blocks with stalls, plus inverse-of-forward round trips
        rand_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            d   = {$urandom, $urandom, $urandom, $urandom};
            inv = 1'($urandom_range(0, 1));
            if (i % 50 == 0) begin
                fwd = model(d, 1'b0);
                send(d, 1'b0, fwd, a1);
                send(fwd, 1'b1, d, a1);
            end else begin
                send(d, inv, model(d, inv), a1);
            end
        end
        rand_en = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        check("final_queue_empty", 128'(exp_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
